// File: rtl/riscv_data_mem.sv
// riscv_data_mem: word-addressed data RAM answering the core's data port.
// Define RISCV_DMEM_WAIT_EN to build the wait-state FSM with busy_o.
module riscv_data_mem #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        busy_o
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [31:0]           mem [DEPTH];
   logic [ADDR_WIDTH-1:0] idx;

   assign idx = addr_i[ADDR_WIDTH+1:2];

`ifdef RISCV_DMEM_WAIT_EN

   // 0 behaves as 1; counter is 4 bits so cap at 15
   localparam int WC = (WAIT_CYCLES < 1)  ? 1 :
                       (WAIT_CYCLES > 15) ? 15 : WAIT_CYCLES;
   localparam logic [3:0] CNT_INIT = 4'(WC - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t                state;
   logic [3:0]            cnt;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] idx_q;
   logic [31:0]           wdata_q;
   logic [31:0]           rdata_q;
   logic                  ram_we;
   logic [1:0]            unused_addr;

   assign unused_addr = addr_i[1:0];
   if (ADDR_WIDTH < 30) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^addr_i[31:ADDR_WIDTH+2];
   end

   assign ram_we = (state == S_WAIT) && (cnt == 4'd0) && we_q && !rst;
   assign data_o = rdata_q;

   // busy follows ce_i in IDLE so the core stalls in its request cycle
   always_comb begin
      busy_o = 1'b0;
      unique case (state)
         S_IDLE:  busy_o = ce_i;
         S_WAIT:  busy_o = 1'b1;
         default: busy_o = 1'b0;
      endcase
   end

   // request capture, wait countdown and read-data register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (ce_i) begin
                  we_q    <= we_i;
                  idx_q   <= idx;
                  wdata_q <= data_i;
                  cnt     <= CNT_INIT;
                  state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  if (!we_q) rdata_q <= mem[idx_q];
                  state <= S_RESP;
               end
            end
            S_RESP: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // RAM write at the end of the wait; contents survive reset
   always_ff @(posedge clk) begin
      if (ram_we) mem[idx_q] <= wdata_q;
   end

`else

   logic [31:0] unused_cfg;
   logic [2:0]  unused_misc;

   assign unused_cfg  = 32'(WAIT_CYCLES);
   assign unused_misc = {rst, addr_i[1:0]};
   if (ADDR_WIDTH < 30) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^addr_i[31:ADDR_WIDTH+2];
   end

   assign busy_o = 1'b0;
   assign data_o = mem[idx];

   // single-cycle write; asynchronous read feeds the core directly
   always_ff @(posedge clk) begin
      if (ce_i && we_i) mem[idx] <= data_i;
   end

`endif

endmodule

// File: tb/tb_riscv_data_mem.sv
// tb_riscv_data_mem: directed checks for riscv_data_mem.
// Covers whichever build RISCV_DMEM_WAIT_EN selects.
module tb_riscv_data_mem;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        busy;
   logic [31:0] rdata0;
   logic        busy0;
   logic        sel;
   int          nvec = 0;
   int          errs = 0;

   always #5 clk = ~clk;

   riscv_data_mem #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .ce_i(ce), .we_i(we),
      .addr_i(addr), .data_i(wdata),
      .data_o(rdata), .busy_o(busy)
   );

   riscv_data_mem #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .ce_i(ce), .we_i(we),
      .addr_i(addr), .data_i(wdata),
      .data_o(rdata0), .busy_o(busy0)
   );

   wire        busy_s  = sel ? busy0  : busy;
   wire [31:0] rdata_s = sel ? rdata0 : rdata;

`ifdef RISCV_DMEM_WAIT_EN

   // one access; counts busy cycles, returns data_o at the RESP cycle
   task automatic do_access(input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic drop,
                            output int nb, output logic [31:0] rd);
      bit got;
      @(posedge clk); #1;
      ce = 1'b1; we = w; addr = a; wdata = d;
      nb = 0; got = 0; rd = 32'hx;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (busy_s) nb++;
         else begin got = 1; rd = rdata_s; end
         if (drop && i == 0) begin
            @(posedge clk); #1;
            ce = 1'b0;
         end
      end
      if (!got) begin
         nvec++; errs++;
         $display("FAIL access_timeout addr=%h busy stuck high", a);
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      ce = 1'b0; we = 1'b0;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; ce = 1'b0; we = 1'b0; addr = 0; wdata = 0; sel = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      nvec++;
      if (busy !== 1'b0) begin
         errs++; $display("FAIL reset_busy got=%b want=0", busy);
      end
      nvec++;
      if (rdata !== 32'h0) begin
         errs++; $display("FAIL reset_data got=%h want=0", rdata);
      end
   endtask

   task automatic test_read();
      int nb; logic [31:0] rd;
      do_access(1'b1, 32'h20, 32'h12345678, 1'b0, nb, rd);
      chk("wr20_busy", 32'(nb), 32'd3);
      idle();
      do_access(1'b0, 32'h20, 32'h0, 1'b0, nb, rd);
      chk("rd20_busy", 32'(nb), 32'd3);
      chk("rd20_data", rd, 32'h12345678);
      idle();
   endtask

   task automatic test_back_to_back();
      int nb; logic [31:0] rd;
      do_access(1'b1, 32'h40, 32'hA5A5A5A5, 1'b0, nb, rd);
      chk("b2b_wr_busy", 32'(nb), 32'd3);
      do_access(1'b0, 32'h40, 32'h0, 1'b0, nb, rd);
      chk("b2b_rd_busy", 32'(nb), 32'd3);
      chk("b2b_rd_data", rd, 32'hA5A5A5A5);
      do_access(1'b1, 32'h44, 32'h0BADF00D, 1'b0, nb, rd);
      chk("wr_keeps_data_o", rd, 32'hA5A5A5A5);
      idle();
   endtask

   task automatic test_wrap();
      int nb; logic [31:0] rd;
      do_access(1'b1, 32'h3, 32'h1, 1'b0, nb, rd);
      idle();
      do_access(1'b0, 32'h1000, 32'h0, 1'b0, nb, rd);
      chk("wrap_rd", rd, 32'h1);
      idle();
   endtask

   task automatic test_ce_drop();
      int nb; logic [31:0] rd;
      do_access(1'b1, 32'h50, 32'h77, 1'b1, nb, rd);
      chk("drop_busy", 32'(nb), 32'd3);
      idle();
      do_access(1'b0, 32'h50, 32'h0, 1'b0, nb, rd);
      chk("drop_rd", rd, 32'h77);
      idle();
   endtask

   task automatic test_reset_mid();
      int nb; logic [31:0] rd;
      do_access(1'b1, 32'h8, 32'h0, 1'b0, nb, rd);
      idle();
      do_access(1'b0, 32'h40, 32'h0, 1'b0, nb, rd);
      idle();
      @(posedge clk); #1;
      ce = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'hFFFF0000;
      @(posedge clk); #1;
      rst = 1'b1; ce = 1'b0; we = 1'b0;
      @(negedge clk);
      chk("rstmid_busy", {31'h0, busy}, 32'h0);
      chk("rstmid_data", rdata, 32'h0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      do_access(1'b0, 32'h8, 32'h0, 1'b0, nb, rd);
      chk("rstmid_ram", rd, 32'h0);
      idle();
   endtask

   task automatic test_wait0();
      int nb; logic [31:0] rd;
      rst = 1'b1; sel = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      do_access(1'b1, 32'h30, 32'h55, 1'b0, nb, rd);
      chk("w0_wr_busy", 32'(nb), 32'd2);
      idle();
      do_access(1'b0, 32'h30, 32'h0, 1'b0, nb, rd);
      chk("w0_rd_busy", 32'(nb), 32'd2);
      chk("w0_rd_data", rd, 32'h55);
      idle();
      sel = 1'b0;
   endtask

   initial begin
      test_reset();
      test_read();
      test_back_to_back();
      test_wrap();
      test_ce_drop();
      test_reset_mid();
      test_wait0();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
      $finish;
   end

`else

   task automatic zw_write(input logic [31:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      ce = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(posedge clk); #1;
      ce = 1'b0; we = 1'b0;
   endtask

   task automatic zw_read(input string nm, input logic [31:0] a,
                          input logic [31:0] exp);
      ce = 1'b1; we = 1'b0; addr = a;
      @(negedge clk);
      nvec++;
      if (rdata !== exp) begin
         errs++;
         $display("FAIL %s got=%h want=%h", nm, rdata, exp);
      end
      nvec++;
      if (busy !== 1'b0 || busy0 !== 1'b0) begin
         errs++;
         $display("FAIL %s_busy got=%b/%b want=0", nm, busy, busy0);
      end
      @(posedge clk); #1;
      ce = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; ce = 1'b0; we = 1'b0; addr = 0; wdata = 0; sel = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      nvec++;
      if (busy !== 1'b0) begin
         errs++; $display("FAIL reset_busy got=%b want=0", busy);
      end
   endtask

   task automatic test_write_read();
      zw_write(32'h10, 32'hDEADBEEF);
      zw_read("rd10", 32'h10, 32'hDEADBEEF);
      zw_write(32'h14, 32'h01234567);
      zw_write(32'hFFC, 32'hCAFEF00D);
      zw_read("rd14", 32'h14, 32'h01234567);
      zw_read("rdFFC", 32'hFFC, 32'hCAFEF00D);
      zw_read("rd10_again", 32'h10, 32'hDEADBEEF);
   endtask

   task automatic test_wrap();
      zw_write(32'h3, 32'h1);
      zw_read("wrap_rd", 32'h1000, 32'h1);
      zw_read("wrap_hi", 32'hFFFF_F002, 32'h1);
   endtask

   task automatic test_no_write();
      @(posedge clk); #1;
      ce = 1'b0; we = 1'b1; addr = 32'h10; wdata = 32'h0;
      @(posedge clk); #1;
      we = 1'b0;
      zw_read("ce0_nowrite", 32'h10, 32'hDEADBEEF);
   endtask

   task automatic test_reset_ram();
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      zw_read("rst_keeps_ram", 32'h14, 32'h01234567);
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_wrap();
      test_no_write();
      test_reset_ram();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
      $finish;
   end

`endif

endmodule
